// File: rtl/host_cmd_router_pkg.sv
// Shared types and constants for the host command router.
package host_cmd_router_pkg;

    localparam int unsigned PSIZE         = 16;
    localparam int unsigned DEST_BITS     = 2;
    localparam int unsigned RD_LAT_PHI    = 4;
    localparam int unsigned RD_LAT_CHARGE = 5;

    typedef logic [DEST_BITS-1:0] dest_t;

    typedef struct packed {
        logic             err;
        logic [PSIZE-1:0] data;
    } rsp_t;

endpackage

// File: rtl/host_cmd_router_rsp_fifo.sv
// Synchronous response FIFO with wrapping pointer pair and occupancy count.
module host_cmd_router_rsp_fifo
    import host_cmd_router_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  rsp_t                   push_data,
    input  logic                   pop,
    output logic                   valid,
    output rsp_t                   head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    rsp_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    // Head is forced to zero when empty so the response bus idles at 0.
    assign head    = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/host_cmd_router.sv
// Routes host commands to BRAM destinations; in-order, credit-limited read responses.
module host_cmd_router
    import host_cmd_router_pkg::*;
#(
    parameter int unsigned         ADDR_W             = 14,
    parameter int unsigned         DEST_W             = 2,
    parameter logic [2**DEST_W-1:0] WR_MASK           = 4'b0011,
    parameter logic [2**DEST_W-1:0] RD_MASK           = 4'b1100,
    parameter int unsigned         RD_LAT [2**DEST_W] = '{0, 0, RD_LAT_PHI, RD_LAT_CHARGE},
    parameter int unsigned         MAX_LAT            = 8,
    parameter int unsigned         RSP_DEPTH          = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_wen,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [PSIZE-1:0]              cmd_data,
    output logic [ADDR_W-DEST_W-1:0]      dst_addr,
    output logic [PSIZE-1:0]              dst_wdata,
    output logic [2**DEST_W-1:0]          dst_wen,
    output logic [2**DEST_W-1:0]          dst_ren,
    input  logic [(2**DEST_W)*PSIZE-1:0]  dst_rdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [PSIZE-1:0]              rsp_data,
    output logic                          rsp_err,
    output logic [7:0]                    err_count
);

    localparam int unsigned NUM_DEST = 2**DEST_W;
    localparam int unsigned BA_W     = ADDR_W - DEST_W;
    localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1);
    localparam int unsigned SLOT_W   = $clog2(MAX_LAT);
    localparam int unsigned CNT_W    = $clog2(RSP_DEPTH) + 1;

    // Illegal reads are tracked with latency 1 so their error response stays in order.
    function automatic logic [LAT_W-1:0] eff_lat(input logic [DEST_W-1:0] d);
        return RD_MASK[d] ? LAT_W'(RD_LAT[d]) : LAT_W'(1);
    endfunction

    logic [DEST_W-1:0] cmd_dest;
    logic [LAT_W-1:0]  cmd_lat;
    logic              cmd_illegal;
    logic              cmd_acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              live_q;
    logic [LAT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_use;

    logic              iss_vld_q;
    logic              iss_err_q;
    logic [DEST_W-1:0] iss_dest_q;
    logic [SLOT_W-1:0] iss_slot;

    logic [MAX_LAT-1:0] trk_vld_q;
    logic [MAX_LAT-1:0] trk_err_q;
    logic [DEST_W-1:0]  trk_dest_q [MAX_LAT];

    logic [PSIZE-1:0]  rdata_arr [NUM_DEST];
    logic              push;
    rsp_t              push_rsp;
    rsp_t              head;

    assign cmd_dest    = cmd_addr[ADDR_W-1 -: DEST_W];
    assign cmd_illegal = cmd_wen ? ~WR_MASK[cmd_dest] : ~RD_MASK[cmd_dest];
    assign cmd_acc     = cmd_valid & cmd_ready;
    assign wr_acc      = cmd_acc & cmd_wen;
    assign rd_acc      = cmd_acc & ~cmd_wen;

    // Reads need a capture slot later than the youngest in-flight one and a free FIFO credit.
    always_comb begin
        cmd_lat    = eff_lat(cmd_dest);
        credit_use = (CNT_W+1)'(inflight_q) + (CNT_W+1)'(fifo_count);
        cmd_ready  = 1'b0;
        if (live_q) begin
            cmd_ready = cmd_wen |
                        ((rem_q < cmd_lat) && (credit_use < (CNT_W+1)'(RSP_DEPTH)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q    <= 1'b0;
            dst_addr  <= '0;
            dst_wdata <= '0;
            dst_wen   <= '0;
            dst_ren   <= '0;
            err_count <= '0;
        end else begin
            live_q  <= 1'b1;
            dst_wen <= '0;
            dst_ren <= '0;
            if (cmd_acc) dst_addr  <= cmd_addr[BA_W-1:0];
            if (wr_acc)  dst_wdata <= cmd_data;
            if (wr_acc && !cmd_illegal) dst_wen <= NUM_DEST'(1) << cmd_dest;
            if (rd_acc && !cmd_illegal) dst_ren <= NUM_DEST'(1) << cmd_dest;
            if (cmd_acc && cmd_illegal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

    assign iss_slot = SLOT_W'(eff_lat(iss_dest_q) - LAT_W'(1));

    // Issue stage feeds the shift tracker; slot 0 captures at the end of the current cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_vld_q  <= 1'b0;
            iss_err_q  <= 1'b0;
            iss_dest_q <= '0;
            rem_q      <= '0;
            inflight_q <= '0;
            trk_vld_q  <= '0;
            trk_err_q  <= '0;
            for (int i = 0; i < int'(MAX_LAT); i++) trk_dest_q[i] <= '0;
        end else begin
            iss_vld_q  <= rd_acc;
            iss_err_q  <= cmd_illegal;
            iss_dest_q <= cmd_dest;

            if (rd_acc)            rem_q <= cmd_lat - LAT_W'(1);
            else if (rem_q != '0)  rem_q <= rem_q - LAT_W'(1);

            if (rd_acc && !push)      inflight_q <= inflight_q + CNT_W'(1);
            else if (!rd_acc && push) inflight_q <= inflight_q - CNT_W'(1);

            for (int i = 0; i < int'(MAX_LAT) - 1; i++) begin
                trk_vld_q[i]  <= trk_vld_q[i+1];
                trk_err_q[i]  <= trk_err_q[i+1];
                trk_dest_q[i] <= trk_dest_q[i+1];
            end
            trk_vld_q[MAX_LAT-1] <= 1'b0;
            if (iss_vld_q) begin
                trk_vld_q[iss_slot]  <= 1'b1;
                trk_err_q[iss_slot]  <= iss_err_q;
                trk_dest_q[iss_slot] <= iss_dest_q;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < int'(NUM_DEST); d++) rdata_arr[d] = dst_rdata[d*PSIZE +: PSIZE];
    end

    assign push = trk_vld_q[0];

    always_comb begin
        push_rsp     = '0;
        push_rsp.err = trk_err_q[0];
        if (!trk_err_q[0]) push_rsp.data = rdata_arr[trk_dest_q[0]];
    end

    host_cmd_router_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_rsp),
        .pop       (rsp_ready),
        .valid     (rsp_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign rsp_data = head.data;
    assign rsp_err  = head.err;

endmodule
